// File: rtl/instr_unpacker.sv
// Fetch-queue row unpacker: issues one live slot per cycle to ID.
// Optional UNPACK_BYPASS_EN presents the head row's first slot combinationally.
package tortoise_pkg;
   localparam int unsigned INSTR_PER_FETCH = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

module instr_unpacker
   import tortoise_pkg::*;
#(
   parameter int unsigned INSTR_PER_ROW = INSTR_PER_FETCH,
   parameter int unsigned IDX_W         = $clog2(INSTR_PER_ROW)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic                               q_empty_i,
   output logic                               q_pop_o,
   input  fetch_entry_t [INSTR_PER_ROW-1:0]   q_instr_i,
   output fetch_entry_t                       instr_o,
   output logic [IDX_W-1:0]                   instr_idx_o,
   output logic                               instr_valid_o,
   input  logic                               instr_ready_i
);

   typedef logic [INSTR_PER_ROW-1:0] mask_t;

   fetch_entry_t [INSTR_PER_ROW-1:0] row_q, row_d, src_row;
   mask_t      pend_q, pend_d, live, src_pend, cur_oh;
   logic [IDX_W-1:0] cur;
   logic       idle, acc, last;
`ifdef UNPACK_BYPASS_EN
   logic       byp;
`endif

   always_comb begin
      live = '0;
      for (int s = 0; s < INSTR_PER_ROW; s++) begin
         live[s] = q_instr_i[s].valid;
      end
   end

   always_comb begin
      idle = (pend_q == '0);
`ifdef UNPACK_BYPASS_EN
      byp      = idle && !q_empty_i && !flush_i;
      src_pend = byp ? live : pend_q;
      src_row  = byp ? q_instr_i : row_q;
`else
      src_pend = pend_q;
      src_row  = row_q;
`endif
      // priority pick: lowest pending slot goes first
      cur = '0;
      for (int s = INSTR_PER_ROW - 1; s >= 0; s--) begin
         if (src_pend[s]) cur = IDX_W'(s);
      end
      cur_oh        = mask_t'(1) << cur;
      instr_o       = src_row[cur];
      instr_idx_o   = cur;
      instr_valid_o = (src_pend != '0) && !flush_i;
      acc           = instr_valid_o && instr_ready_i;
      last          = acc && !idle &&
                      ((pend_q & (pend_q - mask_t'(1))) == '0);
      q_pop_o       = !flush_i && !q_empty_i && (idle || last);

      pend_d = pend_q;
      row_d  = row_q;
      if (flush_i) begin
         pend_d = '0;
      end else begin
         if (acc) pend_d = pend_q & ~cur_oh;
         if (q_pop_o) begin
            row_d  = q_instr_i;
            pend_d = live;
`ifdef UNPACK_BYPASS_EN
            if (byp && acc) pend_d = live & ~cur_oh;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         row_q  <= '0;
      end else begin
         pend_q <= pend_d;
         row_q  <= row_d;
      end
   end

endmodule

// File: tb/tb_instr_unpacker.sv
// Scoreboard bench for instr_unpacker: directed rows, monitor-side checking.
// Latency/gap expectations follow UNPACK_BYPASS_EN when it is defined.
module tb_instr_unpacker;
   import tortoise_pkg::*;

   typedef fetch_entry_t [3:0] row_t;
   typedef struct packed {
      logic [1:0]   idx;
      fetch_entry_t e;
   } exp_t;

`ifdef UNPACK_BYPASS_EN
   localparam int LAT  = 0;
   localparam int SPAN4 = 7;
`else
   localparam int LAT  = 1;
   localparam int SPAN4 = 8;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         q_empty;
   logic         q_pop;
   row_t         q_instr;
   fetch_entry_t instr;
   logic [1:0]   instr_idx;
   logic         instr_valid;
   logic         instr_ready = 1'b0;

   row_t       rows_mem [0:15];
   logic [4:0] wr_ptr = '0;
   logic [4:0] rd_ptr = '0;
   exp_t       sb [$];
   int         acc_log [$];
   int         cyc = 0;
   int         pops = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   assign q_empty = (wr_ptr == rd_ptr) || !rst_n;
   assign q_instr = rows_mem[rd_ptr[3:0]];

   instr_unpacker dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .q_empty_i     (q_empty),
      .q_pop_o       (q_pop),
      .q_instr_i     (q_instr),
      .instr_o       (instr),
      .instr_idx_o   (instr_idx),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready)
   );

   always #5 clk = ~clk;

   // queue model: flushed with the unpacker, emptied by reset
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || flush) rd_ptr <= wr_ptr;
      else if (q_pop && !q_empty) begin
         rd_ptr <= rd_ptr + 5'd1;
         pops   <= pops + 1;
      end
   end

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   function automatic fetch_entry_t mk(input bit v, input int tag);
      fetch_entry_t e;
      e.valid = v;
      e.pc    = 32'h8000_0000 + 32'(tag * 4);
      e.instr = 32'h0000_0013 | (32'(tag) << 20);
      return e;
   endfunction

   task automatic push_row(input logic [3:0] vm, input int base);
      row_t r;
      exp_t x;
      for (int s = 0; s < 4; s++) r[s] = mk(vm[s], base + s);
      rows_mem[wr_ptr[3:0]] = r;
      wr_ptr = wr_ptr + 5'd1;
      for (int s = 0; s < 4; s++) begin
         if (vm[s]) begin
            x.idx = 2'(s);
            x.e   = r[s];
            sb.push_back(x);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (rst_n && instr_valid && instr_ready) begin
         acc_log.push_back(cyc);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got idx %0d, none expected",
                     instr_idx);
         end else begin
            x = sb.pop_front();
            chk("issue_idx", 96'(instr_idx), 96'(x.idx));
            chk("issue_instr", 96'(instr), 96'(x.e));
         end
      end
   end

   task automatic wait_drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(posedge clk);
         k++;
      end
      if (sb.size() != 0) chk({nm, "_timeout"}, 96'(sb.size()), 96'(0));
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input logic [1:0] idx, input string nm);
      int k = 0;
      @(negedge clk);
      while (!(instr_valid && instr_idx == idx) && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (k >= 40) chk({nm, "_timeout"}, 96'(instr_valid), 96'(1));
   endtask

   initial begin
      int a0, p0, pc;
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, p0, pc;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 96'(instr_valid), 96'(0));
      chk("rst_idx", 96'(instr_idx), 96'(0));
      chk("rst_pop", 96'(q_pop), 96'(0));
      @(posedge clk) #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // full row, one pop, four consecutive issues
      instr_ready = 1'b1;
      a0 = acc_log.size();
      p0 = pops;
      pc = cyc;
      push_row(4'b1111, 0);
      wait_drain("t1");
      chk("t1_count", 96'(acc_log.size() - a0), 96'(4));
      chk("t1_pops", 96'(pops - p0), 96'(1));
      chk("t1_latency", 96'(acc_log[a0] - pc), 96'(LAT));
      chk("t1_span", 96'(acc_log[a0+3] - acc_log[a0]), 96'(3));

      // sparse rows issue back-to-back
      a0 = acc_log.size();
      push_row(4'b0101, 10);
      push_row(4'b1000, 20);
      wait_drain("t2");
      chk("t2_count", 96'(acc_log.size() - a0), 96'(3));
      chk("t2_span", 96'(acc_log[a0+2] - acc_log[a0]), 96'(2));

      // stall mid-row
      instr_ready = 1'b0;
      a0 = acc_log.size();
      push_row(4'b1111, 40);
      wait_valid(2'd0, "t3_first");
      @(posedge clk) #1 instr_ready = 1'b1;
      @(posedge clk) #1 instr_ready = 1'b0;
      p0 = pops;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_valid", 96'(instr_valid), 96'(1));
         chk("t3_idx", 96'(instr_idx), 96'(1));
         chk("t3_instr", 96'(instr), 96'(mk(1'b1, 41)));
      end
      chk("t3_nopop", 96'(pops - p0), 96'(0));
      @(posedge clk) #1 instr_ready = 1'b1;
      wait_drain("t3");
      chk("t3_count", 96'(acc_log.size() - a0), 96'(4));

      // empty row sandwiched between full rows
      a0 = acc_log.size();
      p0 = pops;
      push_row(4'b1111, 50);
      push_row(4'b0000, 54);
      push_row(4'b1111, 58);
      wait_drain("t4");
      chk("t4_count", 96'(acc_log.size() - a0), 96'(8));
      chk("t4_pops", 96'(pops - p0), 96'(3));
      chk("t4_span", 96'(acc_log[a0+7] - acc_log[a0]), 96'(SPAN4));

      // flush with idx 1 pending and a row still queued
      instr_ready = 1'b0;
      push_row(4'b1111, 60);
      push_row(4'b1111, 70);
      wait_valid(2'd0, "t5_first");
      @(posedge clk) #1 instr_ready = 1'b1;
      @(posedge clk) #1;
      flush = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("t5_flush_valid", 96'(instr_valid), 96'(0));
      chk("t5_flush_pop", 96'(q_pop), 96'(0));
      @(posedge clk) #1 flush = 1'b0;
      a0 = acc_log.size();
      push_row(4'b0110, 80);
      wait_drain("t5");
      chk("t5_count", 96'(acc_log.size() - a0), 96'(2));

      // reset in the middle of a row
      push_row(4'b1111, 90);
      wait_valid(2'd1, "t6_mid");
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t6_rst_valid", 96'(instr_valid), 96'(0));
      chk("t6_rst_idx", 96'(instr_idx), 96'(0));
      chk("t6_rst_pop", 96'(q_pop), 96'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk) #1;
      a0 = acc_log.size();
      pc = cyc;
      push_row(4'b1111, 100);
      wait_drain("t6");
      chk("t6_count", 96'(acc_log.size() - a0), 96'(4));
      chk("t6_latency", 96'(acc_log[a0] - pc), 96'(LAT));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
